// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the two-master SRAM port arbiter.
// The state encoding is one-hot, so each grant output is a single state flop bit.
package sram_bus_arbiter_pkg;

    typedef enum logic [3:0] {
        ARB_IDLE = 4'b0001,
        ARB_OWN0 = 4'b0010,
        ARB_OWN1 = 4'b0100,
        ARB_TURN = 4'b1000
    } arb_state_e;

    localparam int HOLD_MAX_DEFAULT = 64;
    localparam int WEN_W            = 4;

endpackage

// File: rtl/sram_bus_arbiter_pick2.sv
// Combinational winner select between dcache (0) and icache (1).
// ARB_ROUND_ROBIN_EN: ties go to the port that did not own the bus last; otherwise port 0 wins ties.
module arb_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_owner_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef ARB_ROUND_ROBIN_EN
    assign gnt0_o = req0_i & (~req1_i | last_owner_i);
    assign gnt1_o = req1_i & (~req0_i | ~last_owner_i);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    assign gnt0_o = req0_i;
    assign gnt1_o = req1_i & ~req0_i;
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-style memory port between dcache (m0) and icache (m1), one whole burst at a time.
// Tie policy comes from arb_pick2 (fixed priority, or round robin when ARB_ROUND_ROBIN_EN is defined).
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_en,
    input  logic [WEN_W-1:0] m0_wen,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    output logic             m0_gnt,
    output logic [DW-1:0]    m0_rdata,
    output logic             m0_rvalid,

    input  logic             m1_en,
    input  logic [WEN_W-1:0] m1_wen,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m1_wdata,
    output logic             m1_gnt,
    output logic [DW-1:0]    m1_rdata,
    output logic             m1_rvalid,

    output logic             sram_en,
    output logic [WEN_W-1:0] sram_wen,
    output logic [AW-1:0]    sram_addr,
    output logic [DW-1:0]    sram_wdata,
    input  logic [DW-1:0]    sram_rdata,
    input  logic             sram_rvalid,

    output logic             hold_err
);

    localparam int            CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

    arb_state_e     state_q, state_d;
    logic           last_owner_q, last_owner_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           hold_err_q, hold_err_d;
    logic           pick0, pick1;
    logic           own0, own1, other_waiting;

    arb_pick2 u_pick (
        .req0_i       (m0_en),
        .req1_i       (m1_en),
        .last_owner_i (last_owner_q),
        .gnt0_o       (pick0),
        .gnt1_o       (pick1)
    );

    assign own0          = (state_q == ARB_OWN0);
    assign own1          = (state_q == ARB_OWN1);
    assign other_waiting = (own0 & m1_en) | (own1 & m0_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_err_q   <= hold_err_d;
        end
    end

    // A request arriving as the owner releases is only looked at again from IDLE, after TURN.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick0) begin
                    state_d      = ARB_OWN0;
                    last_owner_d = 1'b0;
                end else if (pick1) begin
                    state_d      = ARB_OWN1;
                    last_owner_d = 1'b1;
                end
            end
            ARB_OWN0: if (!m0_en) state_d = ARB_TURN;
            ARB_OWN1: if (!m1_en) state_d = ARB_TURN;
            ARB_TURN: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Starvation watchdog: only flags, the burst is never cut short.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_err_d = hold_err_q;
        if (!(own0 | own1)) begin
            hold_cnt_d = '0;
        end else if (other_waiting && (hold_cnt_q != HOLD_LIM)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_q == HOLD_LIM - 1'b1) hold_err_d = 1'b1;
        end
    end

    assign m0_gnt   = own0;
    assign m1_gnt   = own1;
    assign hold_err = hold_err_q;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        m0_rdata   = '0;
        m0_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rvalid  = 1'b0;
        if (own0) begin
            sram_en    = m0_en;
            sram_wen   = m0_wen;
            sram_addr  = m0_addr;
            sram_wdata = m0_wdata;
            m0_rdata   = sram_rdata;
            m0_rvalid  = sram_rvalid;
        end else if (own1) begin
            sram_en    = m1_en;
            sram_wen   = m1_wen;
            sram_addr  = m1_addr;
            sram_wdata = m1_wdata;
            m1_rdata   = sram_rdata;
            m1_rvalid  = sram_rvalid;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized scoreboard bench for sram_bus_arbiter against an ownership-timeline model.
// Honours ARB_ROUND_ROBIN_EN the same way as the design build.
module tb_sram_bus_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int HOLD_MAX = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_en, m1_en;
    logic [3:0]    m0_wen, m1_wen;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] srd;
    logic          srv;
    logic          hold_err;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_en(m0_en), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_en(m1_en), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(srd), .sram_rvalid(srv), .hold_err(hold_err)
    );

    // master-side stimulus state
    logic          en[2];
    logic [3:0]    wen[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdata[2];
    bit            pend[2];
    int            left[2];
    int            req_pct[2];
    int            rv_mode;
    int            cyc;

    assign m0_en = en[0];   assign m1_en = en[1];
    assign m0_wen = wen[0]; assign m1_wen = wen[1];
    assign m0_addr = addr[0]; assign m1_addr = addr[1];
    assign m0_wdata = wdata[0]; assign m1_wdata = wdata[1];

    // reference model: who owns the bus, whether we are in the post-burst gap
    int mo_owner;
    bit mo_gap;
    int mo_last;
    int mo_waited;
    bit mo_err;

    logic [DW-1:0] expq0[$];
    logic [DW-1:0] expq1[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1, input int last);
`ifdef ARB_ROUND_ROBIN_EN
        if (r0 && r1) return 1 - last;
`endif
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        mo_owner = -1; mo_gap = 0; mo_last = 1; mo_waited = 0; mo_err = 0;
        expq0.delete(); expq1.delete();
    endtask

    // Ownership lasts while the owner's en is high, then a two-cycle gap before the next grant.
    task automatic model_step();
        if (mo_owner >= 0) begin
            if (en[1 - mo_owner]) begin
                mo_waited++;
                if (mo_waited >= HOLD_MAX) mo_err = 1;
            end
            if (!en[mo_owner]) begin
                mo_owner = -1; mo_gap = 1; mo_waited = 0;
            end
        end else if (mo_gap) begin
            mo_gap = 0;
        end else begin
            mo_owner = pick(en[0], en[1], mo_last);
            if (mo_owner >= 0) mo_last = mo_owner;
        end
    endtask

    task automatic masters_reset();
        for (int x = 0; x < 2; x++) begin
            en[x] = 0; pend[x] = 0; left[x] = 0; wen[x] = 0; addr[x] = 0; wdata[x] = 0; req_pct[x] = 0;
        end
    endtask

    task automatic start_burst(input int x, input int len);
        pend[x] = 1; en[x] = 1; left[x] = len;
        addr[x] = $urandom & 32'hFFFF_FFFC;
        wdata[x] = $urandom;
        wen[x] = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
    endtask

    task automatic cycle();
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [3:0]    e_wen;
        logic          e_en;
        @(posedge clk);
        check("m0_missed_rvalid", 32'(expq0.size()), 0);
        check("m1_missed_rvalid", 32'(expq1.size()), 0);
        model_step();
        #1;
        check("m0_gnt", 32'(m0_gnt), 32'(mo_owner == 0));
        check("m1_gnt", 32'(m1_gnt), 32'(mo_owner == 1));
        check("hold_err", 32'(hold_err), 32'(mo_err));
        for (int x = 0; x < 2; x++) begin
            if (mo_owner == x) begin
                if (left[x] == 0) begin
                    en[x] = 0; pend[x] = 0;
                end else begin
                    left[x]--;
                    addr[x] = addr[x] + 4;
                    wdata[x] = $urandom;
                end
            end else if (!pend[x] && $urandom_range(99) < req_pct[x]) begin
                start_burst(x, $urandom_range(8, 1));
            end
        end
        case (rv_mode)
            1:       srv = (cyc % 3 == 0);
            2:       srv = 1'b1;
            default: srv = ($urandom_range(1) == 1);
        endcase
        srd = $urandom;
        if (srv && mo_owner == 0) expq0.push_back(srd);
        if (srv && mo_owner == 1) expq1.push_back(srd);
        #1;
        e_en = 0; e_wen = 0; e_addr = 0; e_wdata = 0;
        if (mo_owner >= 0) begin
            e_en = en[mo_owner]; e_wen = wen[mo_owner]; e_addr = addr[mo_owner]; e_wdata = wdata[mo_owner];
        end
        check("sram_en", 32'(sram_en), 32'(e_en));
        check("sram_addr", sram_addr, e_addr);
        check("sram_wdata", sram_wdata, e_wdata);
        check("sram_wen", 32'(sram_wen), 32'(e_wen));
        if (mo_owner != 0) check("m0_rdata_idle", m0_rdata, 0);
        if (mo_owner != 1) check("m1_rdata_idle", m1_rdata, 0);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m0_gnt"}, 32'(m0_gnt), 0);
        check({tag, "_m1_gnt"}, 32'(m1_gnt), 0);
        check({tag, "_sram_en"}, 32'(sram_en), 0);
        check({tag, "_sram_addr"}, sram_addr, 0);
        check({tag, "_sram_wen"}, 32'(sram_wen), 0);
        check({tag, "_hold_err"}, 32'(hold_err), 0);
    endtask

    // scoreboard monitor: every rvalid seen by a master must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rvalid) begin
                if (expq0.size() == 0) check("m0_rvalid_unexpected", 1, 0);
                else check("m0_rdata", m0_rdata, expq0.pop_front());
            end
            if (m1_rvalid) begin
                if (expq1.size() == 0) check("m1_rvalid_unexpected", 1, 0);
                else check("m1_rdata", m1_rdata, expq1.pop_front());
            end
        end
    end

    initial begin
        bit reached;
        masters_reset();
        srv = 0; srd = 0; rv_mode = 0; cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0;

        // single 8-beat dcache burst, rvalid every third cycle
        rv_mode = 1;
        start_burst(0, 8);
        run(16);

        // tie from idle
        start_burst(0, 5);
        start_burst(1, 5);
        run(20);

        // icache re-requests immediately while dcache waits
        start_burst(1, 4);
        run(2);
        start_burst(0, 3);
        req_pct[1] = 100;
        run(12);
        req_pct[1] = 0;
        run(20);

        // long burst with the other port waiting: watchdog must fire, grant kept
        rv_mode = 0;
        start_burst(0, 70);
        run(2);
        start_burst(1, 2);
        run(85);
        check("hold_err_sticky", 32'(hold_err), 1);

        // reset in the middle of a burst, at beat 4
        start_burst(0, 8);
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            cycle();
            reached = (mo_owner == 0 && left[0] == 4);
        end
        check("reach_beat4", 32'(reached), 1);
        rst = 1;
        #1;
        check_reset_outputs("midburst_reset");
        masters_reset();
        srv = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        start_burst(1, 3);
        run(10);

        // stray rvalid every cycle, including gap and idle cycles
        rv_mode = 2;
        start_burst(0, 2);
        run(10);

        // random traffic
        rv_mode = 0;
        req_pct[0] = 30;
        req_pct[1] = 30;
        run(2000);
        req_pct[0] = 0;
        req_pct[1] = 0;
        run(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
